// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
//
// Shared definitions for the button/switch conditioner.
//   NCH_DEF          default number of input channels
//   SYNC_STAGES_DEF  default synchroniser depth (flops per channel)
//   DB_CYCLES_DEF    default debounce stability window, in tick cycles
//   cnt_width()      width of the per-channel debounce counter
//
// The debounce feature itself is selected at build time by the macro
// BTN_DEBOUNCE_EN (see btn_conditioner.sv).
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

  localparam int NCH_DEF         = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 16;

  // The counter runs from 0 up to DB_CYCLES-1, so clog2(DB_CYCLES) bits are
  // enough. Never return 0 so the counter declaration stays legal.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : btn_conditioner_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//
// Single-bit multi-flop synchroniser for an asynchronous input.
//
// Parameters
//   DEPTH  number of flops in the chain (>= 2)
//
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous, active-low reset; clears every stage
//   d      in   asynchronous input bit
//   q      out  synchronised output (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  // Stage 0 samples the raw input; each later stage samples its predecessor.
  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[DEPTH-1];

endmodule : sync_chain

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Conditions NCH asynchronous button/switch inputs: each channel is
// synchronised, optionally debounced, and produces a clean level plus
// one-cycle rise/fall pulses.
//
// Build option
//   BTN_DEBOUNCE_EN defined   : per-channel debounce counter; level follows
//                               the synchronised input only after it has
//                               differed for DB_CYCLES consecutive tick cycles.
//   BTN_DEBOUNCE_EN undefined : no counters; level follows the synchronised
//                               input every cycle and tick is ignored.
//
// Parameters
//   NCH          number of independent channels (1..32)
//   SYNC_STAGES  synchroniser depth (>= 2)
//   DB_CYCLES    debounce window in tick cycles (>= 2)
//
// Ports
//   clk       in   system clock, all state changes on posedge
//   rst_n     in   synchronous, active-low reset
//   async_in  in   [NCH] raw asynchronous inputs
//   tick      in   debounce sample enable (counters advance only when high)
//   level     out  [NCH] conditioned level per channel
//   rise      out  [NCH] one-cycle pulse in the first cycle level[i] is 1
//   fall      out  [NCH] one-cycle pulse in the first cycle level[i] is 0
//   any_edge  out  OR of every rise and fall bit, same cycle
//
// Handshake: none. Outputs are plain registered levels/pulses valid every
// cycle; there is no back-pressure.
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] async_in,
  input  logic           tick,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_edge
);

  logic [NCH-1:0] sync;
  logic [NCH-1:0] level_d;
  logic [NCH-1:0] level_q;
  logic [NCH-1:0] rise_d;
  logic [NCH-1:0] rise_q;
  logic [NCH-1:0] fall_d;
  logic [NCH-1:0] fall_q;
  logic           any_edge_d;
  logic           any_edge_q;

`ifndef BTN_DEBOUNCE_EN
  // tick only matters to the debounce counters, which are not built here.
  logic unused_tick;
  assign unused_tick = tick;
`endif

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser and level-update logic. Channels share nothing.
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch

    sync_chain #(
      .DEPTH (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (async_in[ch]),
      .q     (sync[ch])
    );

`ifdef BTN_DEBOUNCE_EN
    localparam int             CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_d;

    // The counter measures how many tick cycles the synchronised input has
    // disagreed with the current level without interruption. Any cycle of
    // agreement (a glitch returning) restarts the window from zero.
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = level_q[ch];
      if (sync[ch] == level_q[ch]) begin
        cnt_d = '0;
      end else if (tick) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d = sync[ch];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign level_d[ch] = lvl_d;
`else
    assign level_d[ch] = sync[ch];
`endif

  end : g_ch

  // ---------------------------------------------------------------------------
  // Edge pulses are derived from the next level so that they are registered
  // in the same edge that updates level, i.e. visible in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_d     = level_d & ~level_q;
    fall_d     = level_q & ~level_d;
    any_edge_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      any_edge_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_edge_q <= any_edge_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign any_edge = any_edge_q;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Bench for btn_conditioner with NCH=4, SYNC_STAGES=2, DB_CYCLES=4. Works for
// both builds (BTN_DEBOUNCE_EN defined or not); expected latencies follow the
// build. Inputs are driven on the falling edge, outputs compared on the
// falling edge against a behavioural model updated on the rising edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;

`ifdef BTN_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  // Edges from the first sampling edge until level/rise show the new value.
  localparam int LAT = DEB ? (SYNC + DB) : (SYNC + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] async_in = '0;
  logic           tick = 1'b1;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           any_edge;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  btn_conditioner #(
    .NCH         (NCH),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (async_in),
    .tick     (tick),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .any_edge (any_edge)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model.
  // The synchroniser is a plain delay line of SYNC samples. A channel's level
  // adopts the delayed input once it has disagreed with the level over DB
  // consecutive tick samples (debounce build), or immediately (plain build).
  // Pulses are the difference between the old and new level.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] m_delay [SYNC];
  logic [NCH-1:0] m_level = '0;
  logic [NCH-1:0] m_rise  = '0;
  logic [NCH-1:0] m_fall  = '0;
  logic           m_any   = 1'b0;
  int             m_ticks_seen [NCH];

  initial begin
    for (int s = 0; s < SYNC; s++) m_delay[s] = '0;
    for (int i = 0; i < NCH; i++) m_ticks_seen[i] = 0;
  end

  always @(posedge clk) begin
    logic [NCH-1:0] seen;
    logic [NCH-1:0] nxt;
    int             t;
    if (!rst_n) begin
      for (int s = 0; s < SYNC; s++) m_delay[s] <= '0;
      for (int i = 0; i < NCH; i++) m_ticks_seen[i] <= 0;
      m_level <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_any   <= 1'b0;
    end else begin
      seen = m_delay[SYNC-1];
      nxt  = m_level;
      for (int i = 0; i < NCH; i++) begin
`ifdef BTN_DEBOUNCE_EN
        t = m_ticks_seen[i];
        if (seen[i] == m_level[i]) begin
          t = 0;
        end else if (tick) begin
          t = t + 1;
          if (t >= DB) begin
            nxt[i] = seen[i];
            t      = 0;
          end
        end
        m_ticks_seen[i] <= t;
`else
        t = 0;
        m_ticks_seen[i] <= t;
        nxt[i] = seen[i];
`endif
      end
      m_delay[0] <= async_in;
      for (int s = 1; s < SYNC; s++) m_delay[s] <= m_delay[s-1];
      m_level <= nxt;
      m_rise  <= nxt & ~m_level;
      m_fall  <= m_level & ~nxt;
      m_any   <= |(nxt ^ m_level);
    end
  end

  // Compare process: every cycle after the first edge.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("level", level, m_level);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      check("any_edge", any_edge, m_any);
      check("rise_and_fall_overlap", rise & fall, 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges until rise[ch] (want_rise) or fall[ch] is seen; -1 on timeout.
  task automatic wait_edge(input int ch, input bit want_rise, input int limit, output int edges);
    edges = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if ((want_rise ? rise[ch] : fall[ch]) === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  // Bouncing pattern: {value of async_in[0], cycles held}.
  logic [7:0] bounce_tab [10] = '{
    8'h11, 8'h01, 8'h12, 8'h01, 8'h13, 8'h02, 8'h18, 8'h01, 8'h02, 8'h08
  };

  // ---------------------------------------------------------------------------
  // Directed test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int cnt_r;
    int cnt_f;
    logic [NCH-1:0] seen_vec;
    logic [7:0] ent;

    // Reset with all inputs low.
    @(negedge clk);
    cmp_en = 1'b1;
    step(2);
    check("reset_level", level, 0);
    check("reset_rise", rise, 0);
    check("reset_any", any_edge, 0);
    rst_n = 1'b1;
    step(10);
    check("idle_level_after_reset", level, 0);

    // Single rising input on channel 0.
    async_in[0] = 1'b1;
    wait_edge(0, 1'b1, 40, n);
    check("ch0_rise_latency", n, LAT);
    check("ch0_level_with_rise", level[0], 1);
    check("ch0_any_with_rise", any_edge, 1);
    @(negedge clk);
    check("ch0_rise_one_cycle", rise[0], 0);
    check("ch0_level_held", level[0], 1);
    async_in[0] = 1'b0;
    wait_edge(0, 1'b0, 40, n);
    check("ch0_fall_latency", n, LAT);
    step(3);

    // Two-cycle glitch on channel 1.
    async_in[1] = 1'b1;
    step(2);
    async_in[1] = 1'b0;
    cnt_r = 0;
    cnt_f = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (rise[1]) cnt_r++;
      if (fall[1]) cnt_f++;
    end
    check("ch1_glitch2_rises", cnt_r, DEB ? 0 : 1);
    check("ch1_glitch2_falls", cnt_f, DEB ? 0 : 1);
    check("ch1_glitch2_level", level[1], 0);

    // One-cycle glitch on channel 1.
    async_in[1] = 1'b1;
    step(1);
    async_in[1] = 1'b0;
    cnt_r = 0;
    cnt_f = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (rise[1]) cnt_r++;
      if (fall[1]) cnt_f++;
    end
    check("ch1_glitch1_rises", cnt_r, DEB ? 0 : 1);
    check("ch1_glitch1_falls", cnt_f, DEB ? 0 : 1);

    // Sparse tick (every 4th edge) on channel 2.
    async_in[2] = 1'b1;
    tick = 1'b1;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (level[2] === 1'b1 && n < 0) n = k;
      tick = ((k % 4) == 0);
    end
    tick = 1'b1;
    check("ch2_sparse_tick_latency", n, DEB ? 17 : 3);
    async_in[2] = 1'b0;
    step(LAT + 4);

    // All channels together.
    async_in = '1;
    seen_vec = '0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rise != 0) begin
        seen_vec = rise;
        n = k;
        break;
      end
    end
    check("all_rise_vector", seen_vec, 4'hf);
    check("all_rise_latency", n, LAT);
    step(4);
    async_in = '0;
    seen_vec = '0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (fall != 0) begin
        seen_vec = fall;
        n = k;
        break;
      end
    end
    check("all_fall_vector", seen_vec, 4'hf);
    check("all_fall_latency", n, LAT);
    step(4);

    // Reset in the middle of a debounce window on channel 3.
    async_in[3] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    check("midreset_level", level, 0);
    check("midreset_rise", rise, 0);
    check("midreset_fall", fall, 0);
    check("midreset_any", any_edge, 0);
    step(1);
    rst_n = 1'b1;
    wait_edge(3, 1'b1, 40, n);
    check("ch3_rise_after_reset", n, LAT);
    async_in[3] = 1'b0;
    step(LAT + 4);

    // Bouncing channel 0, compared every cycle by the model.
    for (int e = 0; e < 10; e++) begin
      ent = bounce_tab[e];
      async_in[0] = ent[4];
      step(int'(ent[3:0]));
    end
    step(LAT + 4);
    check("bounce_final_level", level[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_btn_conditioner
